// File: rtl/snow64_bfloat16_vector_add_sequencer_pkg.sv
// Shared types for the BFloat16 vector-add sequencer: FSM states, lane geometry,
// and the captured-op / result port groups.
package snow64_bfloat16_vector_add_sequencer_pkg;

    localparam int WIDTH__VEC_LANES = 4;
    localparam int WIDTH__LANE      = 16;
    localparam int WIDTH__VEC       = WIDTH__VEC_LANES * WIDTH__LANE;

    typedef enum logic [1:0] {
        StVecAddIdle,
        StVecAddIssue,
        StVecAddWait,
        StVecAddDone
    } StateVecAdd;

    typedef struct packed {
        logic                        sub;
        logic [WIDTH__VEC_LANES-1:0] lane_mask;
        logic [WIDTH__VEC-1:0]       a;
        logic [WIDTH__VEC-1:0]       b;
    } PortIn_VecAdd;

    typedef struct packed {
        logic                  valid;
        logic [WIDTH__VEC-1:0] data;
    } PortOut_VecAdd;

    // Subtraction is a+(-b): only the sign bit moves, exponent/mantissa untouched.
    function automatic logic [WIDTH__LANE-1:0] bf16_neg_if(input logic [WIDTH__LANE-1:0] v,
                                                           input logic sub);
        return {v[WIDTH__LANE-1] ^ sub, v[WIDTH__LANE-2:0]};
    endfunction

endpackage

// File: rtl/snow64_bfloat16_vector_add_sequencer.sv
// Sequences a 4-lane BFloat16 vector add/sub through one scalar adder and reassembles the result.
// Latency: 1 cycle per masked lane, issue + adder latency per enabled lane, result held in DONE.
// Backpressure: stalls issue on add_can_accept_cmd=0; holds result until out_ready; refuses ops outside IDLE.
module snow64_bfloat16_vector_add_sequencer
    import snow64_bfloat16_vector_add_sequencer_pkg::*;
#(
    parameter int NUM_LANES  = WIDTH__VEC_LANES,
    parameter int LANE_WIDTH = WIDTH__LANE
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_start,
    input  logic                            in_sub,
    input  logic [NUM_LANES-1:0]            in_lane_mask,
    input  logic [NUM_LANES*LANE_WIDTH-1:0] in_a,
    input  logic [NUM_LANES*LANE_WIDTH-1:0] in_b,
    output logic                            in_can_accept_cmd,
    output logic                            add_start,
    output logic [LANE_WIDTH-1:0]           add_a,
    output logic [LANE_WIDTH-1:0]           add_b,
    input  logic                            add_data_valid,
    input  logic                            add_can_accept_cmd,
    input  logic [LANE_WIDTH-1:0]           add_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_LANES*LANE_WIDTH-1:0] out_data
);

    localparam int LIDX_W = $clog2(NUM_LANES);
    localparam logic [LIDX_W-1:0] LAST_LANE = LIDX_W'(NUM_LANES - 1);

    StateVecAdd         state_q, state_d;
    logic [LIDX_W-1:0]  lane_q, lane_d;
    PortIn_VecAdd       op_q, op_d;
    PortOut_VecAdd      out_q, out_d;

    logic [LANE_WIDTH-1:0] cur_a;
    logic [LANE_WIDTH-1:0] cur_b;
    logic                  cur_en;
    logic                  last_lane;

    assign cur_a     = op_q.a[lane_q*LANE_WIDTH +: LANE_WIDTH];
    assign cur_b     = bf16_neg_if(op_q.b[lane_q*LANE_WIDTH +: LANE_WIDTH], op_q.sub);
    assign cur_en    = op_q.lane_mask[lane_q];
    assign last_lane = (lane_q == LAST_LANE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StVecAddIdle;
            lane_q  <= '0;
            op_q    <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            op_q    <= op_d;
            out_q   <= out_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        lane_d            = lane_q;
        op_d              = op_q;
        out_d             = out_q;
        in_can_accept_cmd = 1'b0;
        add_start         = 1'b0;
        add_a             = '0;
        add_b             = '0;

        case (state_q)
            StVecAddIdle: begin
                in_can_accept_cmd = 1'b1;
                if (in_start) begin
                    op_d    = '{sub: in_sub, lane_mask: in_lane_mask, a: in_a, b: in_b};
                    lane_d  = '0;
                    state_d = StVecAddIssue;
                end
            end

            StVecAddIssue: begin
                add_a = cur_a;
                add_b = cur_b;
                if (!cur_en) begin
                    out_d.data[lane_q*LANE_WIDTH +: LANE_WIDTH] = cur_a;
                    if (last_lane) begin
                        out_d.valid = 1'b1;
                        state_d     = StVecAddDone;
                    end else begin
                        lane_d = lane_q + 1'b1;
                    end
                end else if (add_can_accept_cmd) begin
                    add_start = 1'b1;
                    state_d   = StVecAddWait;
                end
            end

            StVecAddWait: begin
                // The adder drops data_valid on the edge that takes start, so any valid here is ours.
                add_a = cur_a;
                add_b = cur_b;
                if (add_data_valid) begin
                    out_d.data[lane_q*LANE_WIDTH +: LANE_WIDTH] = add_data;
                    if (last_lane) begin
                        out_d.valid = 1'b1;
                        state_d     = StVecAddDone;
                    end else begin
                        lane_d  = lane_q + 1'b1;
                        state_d = StVecAddIssue;
                    end
                end
            end

            StVecAddDone: begin
                if (out_ready) begin
                    out_d.valid = 1'b0;
                    state_d     = StVecAddIdle;
                end
            end

            default: state_d = StVecAddIdle;
        endcase
    end

    assign out_valid = out_q.valid;
    assign out_data  = out_q.data;

endmodule

// File: doc/snow64_bfloat16_vector_add_sequencer.md
Name: snow64_bfloat16_vector_add_sequencer

Overview:
Upstream/downstream companion of the scalar BFloat16 adder (Snow64BFloat16Add). It accepts one 64-bit vector op of four BFloat16 lanes (add or subtract, with a per-lane enable mask). It issues each enabled lane to the scalar adder through the adder's start / can_accept_cmd / data_valid handshake, then reassembles the lane results into one 64-bit result with a valid/ready output. The adder is instantiated beside this block, not inside it.

Parameters:
NUM_LANES, 4, BFloat16 lanes per vector; lane i occupies bits [16i+15:16i].
LANE_WIDTH, 16, bits per lane (BFloat16); fixed, not to be overridden.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
in_start  in  1  request a vector op; accepted only while in_can_accept_cmd=1
in_sub  in  1  1 = a-b (flip sign bit of each b lane before issue), 0 = a+b
in_lane_mask  in  NUM_LANES  1 = lane computed, 0 = lane bypassed (result lane = a lane)
in_a  in  64  vector operand a
in_b  in  64  vector operand b
in_can_accept_cmd  out  1  high only in ST_IDLE
add_start  out  1  to adder in.start
add_a  out  16  to adder in.a
add_b  out  16  to adder in.b (sign already flipped when sub)
add_data_valid  in  1  from adder out.data_valid
add_can_accept_cmd  in  1  from adder out.can_accept_cmd
add_data  in  16  from adder out.data
out_valid  out  1  result held valid
out_ready  in  1  consumer accepts result
out_data  out  64  assembled result

Behaviour:
- Reset (async, any state): state=ST_IDLE, lane index=0, in_can_accept_cmd=1, add_start=0, add_a=add_b=0, out_valid=0, out_data=0, captured operands/mask/sub cleared.
- ST_IDLE:
  - If in_start=1, capture in_a, in_b, in_sub, in_lane_mask; lane index=0; go ST_ISSUE.
  - in_start while not in ST_IDLE is ignored.
- ST_ISSUE, current lane L:
  - Mask bit 0: result lane L = captured a lane L. Then L++, or go ST_DONE if L=NUM_LANES-1. Takes 1 cycle.
  - Mask bit 1 and add_can_accept_cmd=1: add_start=1 for exactly this cycle, with add_a=a[L] and add_b=b[L]^(in_sub<<15). Go ST_WAIT.
  - Mask bit 1 and add_can_accept_cmd=0: stay, add_start=0.
- ST_WAIT:
  - add_a and add_b are held stable.
  - If add_data_valid=1, store add_data into result lane L. Then L++ and go ST_ISSUE, or go ST_DONE after the last lane.
  - No timeout.
  - The first ST_WAIT cycle never sees stale valid, because the adder clears data_valid on the edge that samples start.
- ST_DONE:
  - out_valid=1; out_data stable.
  - out_ready=1 at a rising edge: out_valid←0 at that edge, go ST_IDLE.
  - in_can_accept_cmd rises on the same edge, so back-to-back ops have no bubble beyond the IDLE cycle.
- Timing with the current adder (3 edges from start sample to data_valid): 4 cycles per enabled lane, 1 per masked lane.
  - All lanes enabled: out_valid high 17 cycles after the accepting edge.
  - Mask=0: out_valid high 5 cycles after, with out_data=in_a.
- Mask=0 at the last lane goes straight to ST_DONE.
- Reset mid-op: sequencer returns to IDLE. The adder (no reset) may finish its op; that completion is ignored in IDLE. The next ISSUE waits on add_can_accept_cmd.
- Sign flip only touches bit 15; exponent and mantissa are untouched.

Decomposition:
- PkgSnow64BFloat16 gains:
  - enum StateVecAdd {StVecAddIdle, StVecAddIssue, StVecAddWait, StVecAddDone}
  - WIDTH__VEC_LANES=4
  - structs PortIn_VecAdd / PortOut_VecAdd mirroring the port groups above
- Lane select/insert is plain indexing; no sub-module needed. The top level wires this block to one Snow64BFloat16Add instance.

Test Plan:
- a=0x3F80_3F80_3F80_3F80, b same, sub=0, mask=4'hF -> out_data=0x4000_4000_4000_4000, out_valid 17 cycles after accept.
- a lanes {0x4040,0x4040,0x4040,0x4040}, b all 0x3F80, sub=1, mask=4'hF -> every lane 0x4000; each lane's add_b issued as 0xBF80.
- mask=4'b0101, a=0x1111_3F80_2222_3F80, b=0x3F80 all lanes, sub=0 -> out_data=0x1111_4000_2222_4000; only 2 add_start pulses; out_valid 11 cycles after accept.
- Hold out_ready=0 for 5 cycles in ST_DONE -> out_valid/out_data stable, in_can_accept_cmd=0, in_start ignored; out_ready=1 -> next edge idle, new op accepted.
- Hold add_can_accept_cmd=0 for 3 cycles in ST_ISSUE -> add_start stays 0, then one single-cycle pulse.
- Assert rst during ST_WAIT of lane 2 -> all outputs at reset values immediately; the stale adder completion is ignored; the next op gives the correct result.
